// File: rtl/seq_code_lock_pkg.sv
// Shared types and sizing helpers for the sequential code lock.
package seq_code_lock_pkg;

    // Lock controller states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CHECK,
        ST_OPEN,
        ST_PROG,
        ST_LOCKOUT
    } lock_state_e;

    // Default geometry of the safe keypad
    localparam int DEF_DIGIT_W  = 4;
    localparam int DEF_CODE_LEN = 4;
    localparam int CODE_W       = DEF_CODE_LEN * DEF_DIGIT_W;

    // Width of a full code word for a given keypad geometry
    function automatic int code_width(input int digit_w, input int code_len);
        return digit_w * code_len;
    endfunction

    // Width needed to hold the larger of two cycle counts down to zero
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/seq_digit_collector.sv
// Shift buffer that gathers digits of a code, shared by code entry and
// reprogramming. New digits enter on the LSB side; the buffer stops
// accepting once it holds a full code.
module seq_digit_collector
    import seq_code_lock_pkg::*;
#(
    parameter int DIGIT_W  = 4,
    parameter int CODE_LEN = 4,
    localparam int CW      = code_width(DIGIT_W, CODE_LEN),
    localparam int CNT_W   = $clog2(CODE_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               shift_en,
    input  logic [DIGIT_W-1:0] digit,
    output logic [CW-1:0]      code_q,
    output logic [CNT_W-1:0]   count,
    output logic               full
);

    assign full = (count == CNT_W'(CODE_LEN));

    // Clear wins over a same-cycle shift; shifts beyond a full code are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_q <= '0;
            count  <= '0;
        end else if (clr) begin
            code_q <= '0;
            count  <= '0;
        end else if (shift_en && !full) begin
            code_q <= (code_q << DIGIT_W) | CW'(digit);
            count  <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_code_lock.sv
// Multi-digit combination lock: code entry, one-cycle compare, timed open
// window with optional reprogramming, and timed lockout after repeated
// failures. All outputs are registered.
module seq_code_lock
    import seq_code_lock_pkg::*;
#(
    parameter int DIGIT_W     = 4,
    parameter int CODE_LEN    = 4,
    parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = 16'h1A2B,
    parameter int MAX_TRIES   = 3,
    parameter int LOCKOUT_CYC = 16,
    parameter int OPEN_CYC    = 8,
    localparam int TW         = $clog2(MAX_TRIES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               clear,
    input  logic               lock_cmd,
    input  logic               prog_en,
    output logic               unlock,
    output logic               alarm,
    output logic               bad_code,
    output logic               prog_done,
    output logic [TW-1:0]      tries_left
);

    localparam int CW    = code_width(DIGIT_W, CODE_LEN);
    localparam int TMR_W = timer_width(LOCKOUT_CYC, OPEN_CYC);
    localparam int CNT_W = $clog2(CODE_LEN + 1);

    lock_state_e        state;
    logic [CW-1:0]      code_reg;
    logic [TMR_W-1:0]   timer;

    logic               col_clr;
    logic               col_shift;
    logic [CW-1:0]      col_q;
    logic [CNT_W-1:0]   col_count;
    logic               col_full;

    logic               last_digit;
    logic               open_take;
    logic               prog_take;
    logic [CW-1:0]      prog_word;

    // The next accepted digit completes a code
    assign last_digit = (col_count == CNT_W'(CODE_LEN - 1));
    // Code word as it will look once the current digit is appended
    assign prog_word  = (col_q << DIGIT_W) | CW'(digit);
    // A programming digit in OPEN only counts if the window is not closing
    assign open_take  = digit_valid && prog_en && !lock_cmd && (timer > TMR_W'(1));
    assign prog_take  = digit_valid && !lock_cmd;

    seq_digit_collector #(
        .DIGIT_W  (DIGIT_W),
        .CODE_LEN (CODE_LEN)
    ) u_collector (
        .clk      (clk),
        .reset    (reset),
        .clr      (col_clr),
        .shift_en (col_shift),
        .digit    (digit),
        .code_q   (col_q),
        .count    (col_count),
        .full     (col_full)
    );

    // Steer the collector: entry digits, flush after compare or commit
    always_comb begin
        col_clr   = 1'b0;
        col_shift = 1'b0;
        case (state)
            ST_IDLE, ST_ENTRY: begin
                col_clr   = clear;
                col_shift = digit_valid;
            end
            ST_CHECK: begin
                col_clr = 1'b1;
            end
            ST_OPEN: begin
                col_clr   = open_take && last_digit;
                col_shift = open_take;
            end
            ST_PROG: begin
                col_clr   = lock_cmd || (prog_take && last_digit);
                col_shift = prog_take;
            end
            default: begin
                col_clr   = 1'b0;
                col_shift = 1'b0;
            end
        endcase
    end

    // Lock controller FSM with registered outputs, timers and stored code
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            code_reg   <= DEFAULT_CODE;
            timer      <= '0;
            unlock     <= 1'b0;
            alarm      <= 1'b0;
            bad_code   <= 1'b0;
            prog_done  <= 1'b0;
            tries_left <= TW'(MAX_TRIES);
        end else begin
            bad_code  <= 1'b0;
            prog_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!clear && digit_valid)
                        state <= last_digit ? ST_CHECK : ST_ENTRY;
                end
                ST_ENTRY: begin
                    if (clear)
                        state <= ST_IDLE;
                    else if (digit_valid && !col_full && last_digit)
                        state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (col_q == code_reg) begin
                        state      <= ST_OPEN;
                        unlock     <= 1'b1;
                        tries_left <= TW'(MAX_TRIES);
                        timer      <= TMR_W'(OPEN_CYC);
                    end else begin
                        bad_code <= 1'b1;
                        if (tries_left <= TW'(1)) begin
                            tries_left <= '0;
                            state      <= ST_LOCKOUT;
                            alarm      <= 1'b1;
                            timer      <= TMR_W'(LOCKOUT_CYC);
                        end else begin
                            tries_left <= tries_left - 1'b1;
                            state      <= ST_IDLE;
                        end
                    end
                end
                ST_OPEN: begin
                    if (lock_cmd || (timer <= TMR_W'(1))) begin
                        unlock <= 1'b0;
                        timer  <= '0;
                        state  <= ST_IDLE;
                    end else if (open_take) begin
                        if (last_digit) begin
                            code_reg  <= prog_word;
                            prog_done <= 1'b1;
                            unlock    <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            state <= ST_PROG;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_PROG: begin
                    if (lock_cmd) begin
                        unlock <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (prog_take && last_digit) begin
                        code_reg  <= prog_word;
                        prog_done <= 1'b1;
                        unlock    <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_LOCKOUT: begin
                    if (timer <= TMR_W'(1)) begin
                        alarm      <= 1'b0;
                        timer      <= '0;
                        tries_left <= TW'(MAX_TRIES);
                        state      <= ST_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_code_lock.md
Name: seq_code_lock

Overview:
Parametrised multi-digit combination lock for the digital safe. It collects a sequence of CODE_LEN digits, each DIGIT_W bits wide, and compares the whole sequence against a stored code. On a match it opens for a bounded time. Repeated failures trigger an alarm and a timed lockout. While open, the stored code can be reprogrammed.

Parameters:
DIGIT_W, 4, width of one entered digit
CODE_LEN, 4, digits per code (>=1)
DEFAULT_CODE, 16'h1A2B, reset value of stored code (CODE_LEN*DIGIT_W bits, first digit in MSBs)
MAX_TRIES, 3, consecutive failures before lockout (>=1)
LOCKOUT_CYC, 16, lockout duration in clk cycles (>=1)
OPEN_CYC, 8, auto-relock timeout in clk cycles (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
digit_valid  in  1  digit qualifier, one digit accepted per high cycle
digit  in  DIGIT_W  entered digit
clear  in  1  abort partial entry
lock_cmd  in  1  relock immediately while open
prog_en  in  1  sampled with the first digit in OPEN; selects programming
unlock  out  1  high while open
alarm  out  1  high during lockout
bad_code  out  1  one-cycle pulse per rejected code
prog_done  out  1  one-cycle pulse when new code committed
tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts before lockout

Behaviour:
- Reset values: state=IDLE; code_reg=DEFAULT_CODE; unlock=0; alarm=0; bad_code=0; prog_done=0; tries_left=MAX_TRIES; digit count=0.
- States: IDLE, ENTRY, CHECK, OPEN, PROG, LOCKOUT. All outputs are registered.
- IDLE/ENTRY: each digit_valid cycle shifts digit into entry buffer (LSB side) and increments count. First digit moves IDLE->ENTRY. When the CODE_LEN-th digit is accepted, go to CHECK next cycle. In ENTRY, digit_valid is ignored while count==CODE_LEN.
- clear in IDLE/ENTRY: buffer and count zeroed, state IDLE, tries_left unchanged. clear has priority over a simultaneous digit_valid. clear is ignored in other states.
- CHECK (exactly 1 cycle, no early exit on a partial mismatch):
  - Full-word compare against code_reg.
  - Match: OPEN, unlock=1 from the next cycle, tries_left=MAX_TRIES, open timer=OPEN_CYC.
  - Mismatch: bad_code pulses 1 cycle and tries_left decrements. If it reaches 0, go to LOCKOUT with alarm=1 and lockout timer=LOCKOUT_CYC. Otherwise go to IDLE.
  - Latency: last digit accepted at cycle N, unlock/alarm/bad_code visible at N+2.
- OPEN:
  - Timer decrements each cycle. On expiry or lock_cmd: unlock=0, state IDLE.
  - lock_cmd beats a same-cycle digit.
  - digit_valid with prog_en=1: PROG. That digit is the first new-code digit, the timer stops, and unlock stays 1.
  - digit_valid with prog_en=0: ignored.
- PROG: collects CODE_LEN digits in total. On the last digit, code_reg is loaded, prog_done pulses, unlock=0, state IDLE.
  - lock_cmd during PROG aborts: code_reg unchanged, state IDLE.
  - clear is ignored in PROG.
- LOCKOUT:
  - All digits, clear and lock_cmd are ignored. alarm=1.
  - Timer reaches 0 after LOCKOUT_CYC cycles; then alarm=0, tries_left=MAX_TRIES, state IDLE.
- Reset mid-operation, any state: immediate return to reset values. code_reg also reverts to DEFAULT_CODE. Programmed codes are volatile.
- Timers use width $clog2(max(LOCKOUT_CYC,OPEN_CYC)+1). No wrap-around: a timer stops at 0.

Decomposition:
- Package seq_code_lock_pkg holds:
  - state enum lock_state_e.
  - CODE_W = CODE_LEN*DIGIT_W.
  - Timer-width helper function.
- Sub-module seq_digit_collector holds the shift buffer, digit count, clear handling and full flag. It is reused by both ENTRY and PROG; the top holds the FSM, timers and code_reg.

Test Plan:
- Digits 1,A,2,B (one per cycle) -> unlock=1 two cycles after the last digit, stays 1 for 8 cycles, then 0; tries_left=3.
- Digits 1,A,2,C -> bad_code pulses once, tries_left=2, unlock=0, alarm=0; a correct code next -> unlock=1, tries_left=3.
- Three wrong codes in a row -> third bad_code then alarm=1 for 16 cycles. During lockout, 1,A,2,B is ignored (unlock stays 0). After lockout: alarm=0, tries_left=3.
- Digits 1,A, then clear, then 1,A,2,B -> unlock=1 (the partial entry is discarded); clear and digit in the same cycle -> digit dropped.
- Open, then prog_en=1 with 7,7,7,7 -> prog_done pulse, unlock=0. Then 1,A,2,B -> bad_code. Then 7,7,7,7 -> unlock=1. Then reset -> 1,A,2,B opens again.
- Reset asserted mid-entry and during LOCKOUT -> all outputs at reset values on the same edge; lock_cmd while open -> unlock=0 next cycle.
